// File: rtl/shift_pipe_pkg.sv
// shift_pipe shared definitions
// op encodings and per-stage sideband bundle
package shift_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    typedef struct packed {
        logic            valid;
        logic [OP_W-1:0] op;
        logic            err;
        logic            carry;
        logic            zero;
    } meta_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_W'(OP_ROR);
    endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// shift_pipe operation/result handshake bundle
// master drives operations, slave is the shifter
interface shift_pipe_if
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 16
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_carry,
        input  out_zero, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_carry,
        output out_zero, out_err
    );

endinterface

// File: rtl/shift_pipe_stage.sv
// shift_pipe single 2^K shift stage
// combinational shift/carry with optional register
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0,
    parameter bit REG   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  meta_t                    d_meta,
    input  logic [WIDTH-1:0]         d_data,
    input  logic [$clog2(WIDTH)-1:0] d_amt,
    output meta_t                    q_meta,
    output logic [WIDTH-1:0]         q_data,
    output logic [$clog2(WIDTH)-1:0] q_amt
);

    localparam int S = 1 << K;

    logic             act;
    logic [WIDTH-1:0] n_data;
    logic             n_carry;
    meta_t            n_meta;
    logic             unused_zero;

    assign unused_zero = d_meta.zero;
    assign act = d_amt[K] && !d_meta.err;

    // shift by 2^K and capture the bit leaving this stage
    always_comb begin
        n_data  = d_data;
        n_carry = d_meta.carry;
        if (act) begin
            case (d_meta.op)
                OP_SLL: begin
                    n_data  = d_data << S;
                    n_carry = d_data[WIDTH-S];
                end
                OP_SRL: begin
                    n_data  = d_data >> S;
                    n_carry = d_data[S-1];
                end
                OP_SRA: begin
                    n_data  = $signed(d_data) >>> S;
                    n_carry = d_data[S-1];
                end
                OP_ROL: begin
                    n_data  = (d_data << S) | (d_data >> (WIDTH - S));
                    n_carry = d_data[WIDTH-S];
                end
                OP_ROR: begin
                    n_data  = (d_data >> S) | (d_data << (WIDTH - S));
                    n_carry = d_data[S-1];
                end
                default: begin
                    n_data  = d_data;
                    n_carry = d_meta.carry;
                end
            endcase
        end
    end

    // sideband follows the data; zero reflects this stage's result
    always_comb begin
        n_meta       = d_meta;
        n_meta.carry = n_carry;
        n_meta.zero  = (n_data == '0);
    end

    if (REG) begin : g_reg
        // stage register, holds on global stall
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_meta <= '0;
                q_data <= '0;
                q_amt  <= '0;
            end else if (adv) begin
                q_meta <= n_meta;
                q_data <= n_data;
                q_amt  <= d_amt;
            end
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, adv};
        assign q_meta = n_meta;
        assign q_data = n_data;
        assign q_amt  = d_amt;
    end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe pipelined multi-mode barrel shifter
// handshake/stall, illegal-op detect, stage chain
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit PIPE  = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    shift_pipe_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    logic             adv;
    meta_t            e_meta;
    meta_t            s_meta [SHW];
    logic [WIDTH-1:0] s_data [SHW];
    logic [SHW-1:0]   s_amt  [SHW];
    logic             unused_tail;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // entry sideband: illegal ops pass data through with err set
    always_comb begin
        e_meta       = '0;
        e_meta.valid = bus.in_valid;
        e_meta.op    = bus.in_op;
        e_meta.err   = !op_legal(bus.in_op);
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        meta_t            i_meta;
        logic [WIDTH-1:0] i_data;
        logic [SHW-1:0]   i_amt;

        if (k == 0) begin : g_head
            assign i_meta = e_meta;
            assign i_data = bus.in_data;
            assign i_amt  = bus.in_amt;
        end else begin : g_link
            assign i_meta = s_meta[k-1];
            assign i_data = s_data[k-1];
            assign i_amt  = s_amt[k-1];
        end

        shift_pipe_stage #(
            .WIDTH (WIDTH),
            .K     (k),
            .REG   (PIPE || (k == SHW - 1))
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv    (adv),
            .d_meta (i_meta),
            .d_data (i_data),
            .d_amt  (i_amt),
            .q_meta (s_meta[k]),
            .q_data (s_data[k]),
            .q_amt  (s_amt[k])
        );
    end

    assign bus.out_valid = s_meta[SHW-1].valid;
    assign bus.out_data  = s_data[SHW-1];
    assign bus.out_carry = s_meta[SHW-1].carry;
    assign bus.out_zero  = s_meta[SHW-1].zero;
    assign bus.out_err   = s_meta[SHW-1].err;

    assign unused_tail = ^{s_meta[SHW-1].op, s_amt[SHW-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe directed bench for shift_pipe
// PIPE=1 and PIPE=0 instances share one stimulus port
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic [15:0] in_data = 16'd0;
    logic [3:0]  in_amt = 4'd0;
    logic        out_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    shift_pipe_if #(.WIDTH(16)) b1 ();
    shift_pipe_if #(.WIDTH(16)) b0 ();

    assign b1.in_valid  = in_valid && !sel;
    assign b0.in_valid  = in_valid && sel;
    assign b1.in_op     = in_op;
    assign b0.in_op     = in_op;
    assign b1.in_data   = in_data;
    assign b0.in_data   = in_data;
    assign b1.in_amt    = in_amt;
    assign b0.in_amt    = in_amt;
    assign b1.out_ready = sel ? 1'b1 : out_ready;
    assign b0.out_ready = sel ? out_ready : 1'b1;

    shift_pipe #(.WIDTH(16), .PIPE(1'b1)) u_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    shift_pipe #(.WIDTH(16), .PIPE(1'b0)) u_p0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    always #5 clk = ~clk;

    logic        o_ready;
    logic        o_valid;
    logic [18:0] o_res;

    assign o_ready = sel ? b0.in_ready : b1.in_ready;
    assign o_valid = sel ? b0.out_valid : b1.out_valid;
    assign o_res   = sel ?
        {b0.out_err, b0.out_zero, b0.out_carry, b0.out_data} :
        {b1.out_err, b1.out_zero, b1.out_carry, b1.out_data};

    logic [2:0]  v_op   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [15:0] v_data [6] = '{16'h00F0, 16'h1234, 16'hF000,
                                16'h1234, 16'h00FF, 16'h8000};
    logic [3:0]  v_amt  [6] = '{4'd4, 4'd8, 4'd12, 4'd4, 4'd4, 4'd1};
    logic [18:0] v_exp  [6] = '{{3'b000, 16'h0F00}, {3'b000, 16'h0012},
                                {3'b000, 16'hFFFF}, {3'b001, 16'h2341},
                                {3'b001, 16'hF00F}, {3'b011, 16'h0000}};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp = {err, zero, carry, data}
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [15:0] data, input logic [3:0] amt,
                          input logic [18:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_amt   = amt;
        #1;
        chk({tag, "_rdy"}, 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, 32'(o_res), 32'(exp));
        @(posedge clk);
    endtask

    task automatic stream(input string tag);
        int sent = 0;
        int rcv = 0;
        logic stalled = 1'b0;
        logic [18:0] held = '0;
        for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                in_op   = v_op[sent];
                in_data = v_data[sent];
                in_amt  = v_amt[sent];
            end
            #1;
            if (stalled) begin
                chk({tag, "_hold_v"}, 32'(o_valid), 32'd1);
                chk({tag, "_hold_d"}, 32'(o_res), 32'(held));
            end
            if (o_valid && !out_ready)
                chk({tag, "_stall_rdy"}, 32'(o_ready), 32'd0);
            stalled = o_valid && !out_ready;
            held    = o_res;
            if (o_valid && out_ready) begin
                chk($sformatf("%s_r%0d", tag, rcv), 32'(o_res),
                    32'(v_exp[rcv]));
                rcv++;
            end
            if (in_valid && o_ready)
                sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 32'(rcv), 32'd6);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk({tag, "_nodup"}, 32'(o_valid), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", 32'(b1.in_ready), 32'd1);
        chk("rst_out1", {12'd0, b1.out_valid, b1.out_err, b1.out_zero,
            b1.out_carry, b1.out_data}, 32'd0);
        chk("rst_out0", {12'd0, b0.out_valid, b0.out_err, b0.out_zero,
            b0.out_carry, b0.out_data}, 32'd0);

        run_op("sll15", 3'd0, 16'h0001, 4'd15, {3'b000, 16'h8000}, 4);
        run_op("sll1", 3'd0, 16'h8001, 4'd1, {3'b001, 16'h0002}, 4);
        run_op("srl4", 3'd1, 16'h8000, 4'd4, {3'b000, 16'h0800}, 4);
        run_op("sra4", 3'd2, 16'h8000, 4'd4, {3'b000, 16'hF800}, 4);
        run_op("srl1z", 3'd1, 16'h0001, 4'd1, {3'b011, 16'h0000}, 4);
        run_op("ror1", 3'd4, 16'h0001, 4'd1, {3'b001, 16'h8000}, 4);
        run_op("rol4", 3'd3, 16'h8001, 4'd4, {3'b000, 16'h0018}, 4);
        run_op("amt0", 3'd1, 16'hA5A5, 4'd0, {3'b000, 16'hA5A5}, 4);
        run_op("illegal", 3'd7, 16'h1234, 4'd5, {3'b100, 16'h1234}, 4);
        run_op("legal", 3'd0, 16'h0003, 4'd2, {3'b000, 16'h000C}, 4);

        stream("s1");

        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = 16'h0001;
        in_amt   = 4'd1;
        @(negedge clk);
        in_data  = 16'h0002;
        @(negedge clk);
        in_data  = 16'h0004;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        #1;
        chk("flush_v", 32'(o_valid), 32'd0);
        chk("flush_d", 32'(o_res), 32'd0);
        chk("flush_rdy", 32'(o_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("flush_stale", 32'(o_valid), 32'd0);
        end

        @(negedge clk);
        sel = 1'b1;
        run_op("p0_ror15", 3'd4, 16'h4000, 4'd15, {3'b001, 16'h8000}, 1);
        run_op("p0_sra4", 3'd2, 16'h8000, 4'd4, {3'b000, 16'hF800}, 1);
        run_op("p0_err", 3'd5, 16'h00FF, 4'd3, {3'b100, 16'h00FF}, 1);
        stream("s0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
